// File: rtl/regfile_sb_if.sv
// Operand-read, issue and write-back bundle for the scoreboarded register file.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wbdata;
  logic              issue_valid;
  logic [ADDR_W-1:0] issue_rd;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [CNT_W-1:0]  busy_cnt;

  modport master (
    output we, waddr, wbdata,
    output issue_valid, issue_rd,
    output rs1, rs2,
    input  rs1_data, rs2_data,
    input  rs1_busy, rs2_busy,
    input  busy_cnt
  );

  modport slave (
    input  we, waddr, wbdata,
    input  issue_valid, issue_rd,
    input  rs1, rs2,
    output rs1_data, rs2_data,
    output rs1_busy, rs2_busy,
    output busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// 2R1W register file with write-to-read bypass and busy-bit scoreboard.
// REGFILE_ZERO_REG_EN hardwires register 0 to zero (RISC-V x0).
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave rf
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              wr_ok;
  logic              iss_ok;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              bz1;
  logic              bz2;

  // Address may be written or marked busy.
  function automatic logic reg_ok(
    input logic [ADDR_W-1:0] a
  );
    logic ok;
    ok = int'(a) < DEPTH;
`ifdef REGFILE_ZERO_REG_EN
    ok = ok && (a != '0);
`else
    ok = ok;
`endif
    return ok;
  endfunction

  always_comb begin
    wr_ok  = rf.we && reg_ok(rf.waddr);
    iss_ok = rf.issue_valid
          && reg_ok(rf.issue_rd);
  end

  // Issue beats write-back on the same register.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    cnt_d  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_ok && rf.waddr == ADDR_W'(i)) begin
        mem_d[i] = rf.wbdata;
      end
      if (iss_ok
          && rf.issue_rd == ADDR_W'(i)) begin
        busy_d[i] = 1'b1;
      end else if (wr_ok
          && rf.waddr == ADDR_W'(i)) begin
        busy_d[i] = 1'b0;
      end
      cnt_d = cnt_d + CNT_W'(busy_d[i]);
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    bz1 = 1'b0;
    bz2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rf.rs1 == ADDR_W'(i)) begin
        rd1 = mem_q[i];
        bz1 = busy_q[i];
      end
      if (rf.rs2 == ADDR_W'(i)) begin
        rd2 = mem_q[i];
        bz2 = busy_q[i];
      end
    end
    // Result in flight this cycle is forwarded.
    if (wr_ok && rf.waddr == rf.rs1) begin
      rd1 = rf.wbdata;
      bz1 = 1'b0;
    end
    if (wr_ok && rf.waddr == rf.rs2) begin
      rd2 = rf.wbdata;
      bz2 = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rf.rs1_data = rd1;
  assign rf.rs2_data = rd2;
  assign rf.rs1_busy = bz1;
  assign rf.rs2_busy = bz2;
  assign rf.busy_cnt = cnt_q;

  a_cnt_max: assert property (
    @(posedge clk) disable iff (!reset)
    int'(cnt_q) <= DEPTH
  );

endmodule
